// File: rtl/count_display_driver.sv
// Samples a 4-bit up/down counter, scans its decimal value (00-15) onto a two-digit
// multiplexed 7-segment display with leading-zero suppression, and tallies wrap-arounds.
module count_display_driver #(
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    input  logic       down_counting_boolean,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       wrap_pulse,
    output logic [7:0] wrap_total
);

    localparam int TMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : TW'(0);
    localparam logic          HAS_BLANK  = (BLANK_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_SHOW_T  = 3'd1,
        ST_BLANK_A = 3'd2,
        ST_SHOW_U  = 3'd3,
        ST_BLANK_B = 3'd4
    } state_t;

    // Decimal digit to {g,f,e,d,c,b,a}; non-decimal codes stay dark.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    logic [3:0]    r_count_q;
    logic          r_valid;
    logic          r_wrap_pulse;
    logic [7:0]    r_wrap_total;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_tens;
    logic [3:0]    r_units;
    logic [6:0]    r_seg;
    logic [1:0]    r_digit_en;

    logic       w_tens;
    logic [3:0] w_units;
    logic       w_up_wrap;
    logic       w_down_wrap;
    logic       w_wrap;

    assign w_tens      = (r_count_q >= 4'd10);
    assign w_units     = w_tens ? (r_count_q - 4'd10) : r_count_q;
    assign w_up_wrap   = r_valid && (r_count_q == 4'd15) && (count == 4'd0)  && !down_counting_boolean;
    assign w_down_wrap = r_valid && (r_count_q == 4'd0)  && (count == 4'd15) &&  down_counting_boolean;
    assign w_wrap      = w_up_wrap || w_down_wrap;

    // Input sampling, wrap strobe and saturating wrap tally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q    <= 4'd0;
            r_valid      <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_total <= 8'd0;
        end else begin
            r_count_q    <= count;
            r_valid      <= 1'b1;
            r_wrap_pulse <= w_wrap;
            if (w_wrap && (r_wrap_total != 8'd255)) begin
                r_wrap_total <= r_wrap_total + 8'd1;
            end else begin
                r_wrap_total <= r_wrap_total;
            end
        end
    end

    // Scan FSM; seg/digit_en are loaded with the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_timer    <= TW'(0);
            r_tens     <= 1'b0;
            r_units    <= 4'd0;
            r_seg      <= 7'h00;
            r_digit_en <= 2'b00;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_tens     <= w_tens;
                    r_units    <= w_units;
                    r_timer    <= TW'(0);
                    r_state    <= ST_SHOW_T;
                    r_seg      <= w_tens ? 7'h06 : 7'h00;
                    r_digit_en <= w_tens ? 2'b10 : 2'b00;
                end
                ST_SHOW_T: begin
                    if (r_timer == SCAN_LAST) begin
                        r_timer <= TW'(0);
                        if (HAS_BLANK) begin
                            r_state    <= ST_BLANK_A;
                            r_seg      <= 7'h00;
                            r_digit_en <= 2'b00;
                        end else begin
                            r_state    <= ST_SHOW_U;
                            r_seg      <= seg_code(r_units);
                            r_digit_en <= 2'b01;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_BLANK_A: begin
                    if (r_timer == BLANK_LAST) begin
                        r_timer    <= TW'(0);
                        r_state    <= ST_SHOW_U;
                        r_seg      <= seg_code(r_units);
                        r_digit_en <= 2'b01;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_SHOW_U: begin
                    if (r_timer == SCAN_LAST) begin
                        r_timer    <= TW'(0);
                        r_seg      <= 7'h00;
                        r_digit_en <= 2'b00;
                        if (HAS_BLANK) begin
                            r_state <= ST_BLANK_B;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_BLANK_B: begin
                    if (r_timer == BLANK_LAST) begin
                        r_timer <= TW'(0);
                        r_state <= ST_LOAD;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                    r_seg      <= 7'h00;
                    r_digit_en <= 2'b00;
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_timer    <= TW'(0);
                    r_seg      <= 7'h00;
                    r_digit_en <= 2'b00;
                end
            endcase
        end
    end

    assign seg        = r_seg;
    assign digit_en   = r_digit_en;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_total = r_wrap_total;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench: behavioural model feeds a scoreboard queue, plus a table of
// hand-computed digit codes checked while each value is held.
module tb_count_display_driver;

    localparam int S  = 4;
    localparam int BA = 1;
    localparam int BB = 0;
    localparam int LA = 2 * S + 2 * BA + 1;
    localparam int LB = 2 * S + 2 * BB + 1;

    typedef struct {
        logic [6:0] seg_a;
        logic [1:0] en_a;
        logic [6:0] seg_b;
        logic [1:0] en_b;
        logic       pulse;
        logic [7:0] total;
        logic       tab_chk;
        logic [6:0] tab_seg;
        logic [1:0] tab_en;
        int         tab_val;
    } exp_t;

    typedef struct {
        logic [3:0] value;
        logic [6:0] tens_seg;
        logic [1:0] tens_en;
        logic [6:0] units_seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt = 4'd0;
    logic       dir = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic [1:0] en_a, en_b;
    logic       pulse_a, pulse_b;
    logic [7:0] total_a, total_b;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    vec_t vecs[16];

    int         m_pa, m_pb;
    logic [3:0] m_cq, m_va, m_vb;
    logic       m_valid, m_pulse;
    logic [7:0] m_total;

    count_display_driver #(.SCAN_DIV(S), .BLANK_CYCLES(BA)) dut_a (
        .clk(clk), .reset(reset), .count(cnt), .down_counting_boolean(dir),
        .seg(seg_a), .digit_en(en_a), .wrap_pulse(pulse_a), .wrap_total(total_a)
    );

    count_display_driver #(.SCAN_DIV(S), .BLANK_CYCLES(BB)) dut_b (
        .clk(clk), .reset(reset), .count(cnt), .down_counting_boolean(dir),
        .seg(seg_b), .digit_en(en_b), .wrap_pulse(pulse_b), .wrap_total(total_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lut(input int d);
        logic [6:0] c;
        case (d)
            0: c = 7'h3F;  1: c = 7'h06;  2: c = 7'h5B;  3: c = 7'h4F;  4: c = 7'h66;
            5: c = 7'h6D;  6: c = 7'h7D;  7: c = 7'h07;  8: c = 7'h7F;  9: c = 7'h6F;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    // Expected {seg, digit_en} at frame position p (0 = LOAD) showing value v.
    function automatic logic [8:0] disp(input int p, input int b, input logic [3:0] v);
        int vi;
        vi = int'(v);
        if (p >= 1 && p <= S) return (vi >= 10) ? {7'h06, 2'b10} : 9'd0;
        if (p >= S + b + 1 && p <= 2 * S + b) return {lut(vi % 10), 2'b01};
        return 9'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic rst, input logic [3:0] c, input logic d, input int vi);
        exp_t e;
        logic wrap;
        logic [8:0] da, db;
        @(negedge clk);
        #1;
        reset = rst;
        cnt   = c;
        dir   = d;
        if (rst) begin
            m_pa = 0; m_pb = 0; m_cq = 4'd0; m_va = 4'd0; m_vb = 4'd0;
            m_valid = 1'b0; m_pulse = 1'b0; m_total = 8'd0;
        end else begin
            wrap = m_valid && ((m_cq == 4'd15 && c == 4'd0 && !d) || (m_cq == 4'd0 && c == 4'd15 && d));
            m_pulse = wrap;
            if (wrap && m_total != 8'd255) m_total = m_total + 8'd1;
            if (m_pa == 0) m_va = m_cq;
            if (m_pb == 0) m_vb = m_cq;
            m_pa = (m_pa + 1) % LA;
            m_pb = (m_pb + 1) % LB;
            m_cq = c;
            m_valid = 1'b1;
        end
        da = disp(m_pa, BA, m_va);
        db = disp(m_pb, BB, m_vb);
        e.seg_a = da[8:2]; e.en_a = da[1:0];
        e.seg_b = db[8:2]; e.en_b = db[1:0];
        e.pulse = m_pulse; e.total = m_total;
        e.tab_val = vi; e.tab_chk = 1'b0; e.tab_seg = 7'h00; e.tab_en = 2'b00;
        if (vi >= 0 && m_pa >= 1 && m_pa <= S) begin
            e.tab_chk = 1'b1; e.tab_seg = vecs[vi].tens_seg; e.tab_en = vecs[vi].tens_en;
        end else if (vi >= 0 && m_pa >= S + BA + 1 && m_pa <= 2 * S + BA) begin
            e.tab_chk = 1'b1; e.tab_seg = vecs[vi].units_seg; e.tab_en = 2'b01;
        end
        sb.push_back(e);
    endtask

    // Scoreboard: one expectation per clock, consumed after the edge it describes.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("seg_a", 32'(seg_a), 32'(e.seg_a));
            chk("digit_en_a", 32'(en_a), 32'(e.en_a));
            chk("seg_b", 32'(seg_b), 32'(e.seg_b));
            chk("digit_en_b", 32'(en_b), 32'(e.en_b));
            chk("wrap_pulse_a", 32'(pulse_a), 32'(e.pulse));
            chk("wrap_total_a", 32'(total_a), 32'(e.total));
            chk("wrap_pulse_b", 32'(pulse_b), 32'(e.pulse));
            chk("wrap_total_b", 32'(total_b), 32'(e.total));
            if (e.tab_chk) begin
                chk($sformatf("table_seg v=%0d", e.tab_val), 32'(seg_a), 32'(e.tab_seg));
                chk($sformatf("table_en v=%0d", e.tab_val), 32'(en_a), 32'(e.tab_en));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4'd0,  7'h00, 2'b00, 7'h3F};
        vecs[1]  = '{4'd1,  7'h00, 2'b00, 7'h06};
        vecs[2]  = '{4'd2,  7'h00, 2'b00, 7'h5B};
        vecs[3]  = '{4'd3,  7'h00, 2'b00, 7'h4F};
        vecs[4]  = '{4'd4,  7'h00, 2'b00, 7'h66};
        vecs[5]  = '{4'd5,  7'h00, 2'b00, 7'h6D};
        vecs[6]  = '{4'd6,  7'h00, 2'b00, 7'h7D};
        vecs[7]  = '{4'd7,  7'h00, 2'b00, 7'h07};
        vecs[8]  = '{4'd8,  7'h00, 2'b00, 7'h7F};
        vecs[9]  = '{4'd9,  7'h00, 2'b00, 7'h6F};
        vecs[10] = '{4'd10, 7'h06, 2'b10, 7'h3F};
        vecs[11] = '{4'd11, 7'h06, 2'b10, 7'h06};
        vecs[12] = '{4'd12, 7'h06, 2'b10, 7'h5B};
        vecs[13] = '{4'd13, 7'h06, 2'b10, 7'h4F};
        vecs[14] = '{4'd14, 7'h06, 2'b10, 7'h66};
        vecs[15] = '{4'd15, 7'h06, 2'b10, 7'h6D};

        tick(1'b1, 4'd0, 1'b0, -1);
        tick(1'b1, 4'd0, 1'b0, -1);

        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i <= 2 * LA; i++) begin
                tick(1'b0, vecs[v].value, 1'b0, (i >= LA) ? v : -1);
            end
        end

        // Up wrap, down wrap, and a mismatched-direction jump.
        tick(1'b0, 4'd14, 1'b0, -1); tick(1'b0, 4'd15, 1'b0, -1);
        tick(1'b0, 4'd0,  1'b0, -1); tick(1'b0, 4'd1,  1'b0, -1);
        tick(1'b0, 4'd1,  1'b1, -1); tick(1'b0, 4'd0,  1'b1, -1);
        tick(1'b0, 4'd15, 1'b1, -1); tick(1'b0, 4'd14, 1'b1, -1);
        tick(1'b0, 4'd0,  1'b0, -1); tick(1'b0, 4'd15, 1'b0, -1);
        tick(1'b0, 4'd0,  1'b1, -1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd15, 1'b0, -1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 1'b1, -1);

        // Reset in the middle of the units digit, then resume.
        for (int i = 0; i < 2 * LA; i++) begin
            tick(1'b0, 4'd11, 1'b0, -1);
            if (i > LA && m_pa == S + BA + 2) break;
        end
        tick(1'b1, 4'd11, 1'b0, -1);
        for (int i = 0; i < LA + 3; i++) tick(1'b0, 4'd11, 1'b0, -1);

        // 300 back-to-back wraps: tally must saturate at 255.
        tick(1'b0, 4'd15, 1'b1, -1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) tick(1'b0, 4'd0, 1'b0, -1);
            else tick(1'b0, 4'd15, 1'b1, -1);
        end
        for (int i = 0; i < LA; i++) tick(1'b0, 4'd5, 1'b0, -1);

        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
